// File: rtl/core_pkg.sv
// Shared RV32I core definitions: funct3 load/store encodings, LSU state
// encoding, byte-enable patterns and access-size decode helpers.
package core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Reserved load encodings fall through to a full word.
  function automatic acc_size_e load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  // Reserved store encodings (including 1xx) fall through to a full word.
  function automatic acc_size_e store_size(input logic [2:0] f3);
    case (f3)
      F3_SB:   return SZ_BYTE;
      F3_SH:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword from the bus word
// and sign- or zero-extends it according to funct3.
module load_align
  import core_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension; bit 2 of funct3 marks unsigned loads.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (load_size(funct3))
      SZ_BYTE: data = funct3[2] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: data = funct3[2] ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: req/gnt/rvalid data-bus master with pipeline
// stall and aligned load result. Optional LSU_MISALIGN_TRAP_EN adds misalign_o.
module load_store_unit
  import core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  output logic              lsu_stall_o,
  output logic [DATA_W-1:0] mem_o,
  output logic              mem_valid_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_e        state, next_state;
  logic              req_we;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              access, misaligned, issue, bus_active, stall_raw, load_done;
  logic              cur_we;
  logic [2:0]        cur_f3;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [31:0]       aligned;

  assign access = mem_read_i | mem_write_i;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = is_misaligned(mem_write_i ? store_size(funct3_i) : load_size(funct3_i),
                                    addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif
  assign issue      = access & ~misaligned;
  // Reset gates the bus so a request drops the instant reset asserts.
  assign bus_active = ~reset & (((state == IDLE) & issue) | (state == WAIT_GNT));
  assign load_done  = (state == WAIT_RESP) & dbus_rvalid_i;

  // In IDLE the bus follows the pipeline inputs; afterwards the latched request.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = mem_write_i;
      cur_f3    = funct3_i;
      cur_addr  = addr_i;
      cur_wdata = wdata_i;
    end else begin
      cur_we    = req_we;
      cur_f3    = req_f3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  // Bus encoding: word address, byte enables and lane-replicated store data.
  always_comb begin
    dbus_req_o   = bus_active;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = 4'b0000;
    dbus_wdata_o = '0;
    if (bus_active) begin
      dbus_we_o   = cur_we;
      dbus_addr_o = {cur_addr[ADDR_W-1:2], 2'b00};
      if (cur_we) begin
        case (store_size(cur_f3))
          SZ_BYTE: begin
            dbus_be_o    = BE_BYTE << cur_addr[1:0];
            dbus_wdata_o = {4{cur_wdata[7:0]}};
          end
          SZ_HALF: begin
            dbus_be_o    = cur_addr[1] ? BE_HALF_HI : BE_HALF_LO;
            dbus_wdata_o = {2{cur_wdata[15:0]}};
          end
          default: begin
            dbus_be_o    = BE_WORD;
            dbus_wdata_o = cur_wdata;
          end
        endcase
      end else begin
        dbus_be_o = BE_WORD;
      end
    end else begin
      dbus_we_o = 1'b0;
    end
  end

  // Next state and raw stall; a store completes on gnt, a load on rvalid.
  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          stall_raw = ~(mem_write_i & dbus_gnt_i);
          if (dbus_gnt_i) begin
            next_state = mem_write_i ? IDLE : WAIT_RESP;
          end else begin
            next_state = WAIT_GNT;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_GNT: begin
        stall_raw = ~(req_we & dbus_gnt_i);
        if (dbus_gnt_i) begin
          next_state = req_we ? IDLE : WAIT_RESP;
        end else begin
          next_state = WAIT_GNT;
        end
      end
      WAIT_RESP: begin
        stall_raw = ~dbus_rvalid_i;
        if (dbus_rvalid_i) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT_RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign lsu_stall_o = stall_raw & ~reset;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Request register, captured whenever an access is accepted in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_we    <= 1'b0;
      req_f3    <= 3'b000;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if ((state == IDLE) && issue) begin
      req_we    <= mem_write_i;
      req_f3    <= funct3_i;
      req_addr  <= addr_i;
      req_wdata <= wdata_i;
    end
  end

  load_align u_load_align (
    .rdata   (dbus_rdata_i),
    .funct3  (req_f3),
    .addr_lo (req_addr[1:0]),
    .data    (aligned)
  );

  // Load result register and its one-cycle valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_o       <= '0;
      mem_valid_o <= 1'b0;
    end else begin
      mem_valid_o <= load_done;
      if (load_done) mem_o <= aligned;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment flag, pulsed the cycle after a rejected access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_o <= 1'b0;
    else       misalign_o <= (state == IDLE) & access & misaligned;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a transaction-level
// model of bus encoding, stall timing and load extension (LSU_MISALIGN_TRAP_EN aware).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        lsu_stall_o;
  logic [31:0] mem_o;
  logic        mem_valid_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
  logic        exp_mis = 1'b0, pend_mis = 1'b0;
`endif

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
    .lsu_stall_o(lsu_stall_o), .mem_o(mem_o), .mem_valid_o(mem_valid_o)
`ifdef LSU_MISALIGN_TRAP_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic        chk_en = 1'b0;
  logic        exp_req = 1'b0, exp_we = 1'b0, exp_stall = 1'b0, exp_valid = 1'b0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, model_mem = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_mem = 32'h0;
  logic [31:0] obs_addr = 32'h0, obs_wdata = 32'h0;
  logic [3:0]  obs_be = 4'h0;
  int          obs_stall = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model ----
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
    logic [31:0] b, h;
    b = d >> (8 * a[1:0]);
    h = d >> (16 * a[1]);
    case (f3)
      3'd0:    return {{24{b[7]}}, b[7:0]};
      3'd4:    return {24'h0, b[7:0]};
      3'd1:    return {{16{h[15]}}, h[15:0]};
      3'd5:    return {16'h0, h[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return {4{w[7:0]}};
      3'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic m_misaligned(input logic st, input logic [2:0] f3,
                                        input logic [31:0] a);
    int bytes;
    if (st) bytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    bytes = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (a % bytes) != 0;
  endfunction

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("req", dbus_req_o, exp_req);
      chk1("stall", lsu_stall_o, exp_stall);
      chk1("mem_valid", mem_valid_o, exp_valid);
      chk32("mem_o", mem_o, model_mem);
`ifdef LSU_MISALIGN_TRAP_EN
      chk1("misalign", misalign_o, exp_mis);
`endif
      if (exp_req) begin
        chk1("we", dbus_we_o, exp_we);
        chk32("addr", dbus_addr_o, exp_addr);
        if (exp_we) begin
          chk32("be", {28'h0, dbus_be_o}, {28'h0, exp_be});
          chk32("wdata", dbus_wdata_o, exp_wdata);
        end
      end
      if (dbus_req_o) begin
        obs_addr  = dbus_addr_o;
        obs_be    = dbus_be_o;
        obs_wdata = dbus_wdata_o;
      end
      if (lsu_stall_o) obs_stall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    exp_valid = pend_valid;
    if (pend_valid) model_mem = pend_mem;
    pend_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    exp_mis  = pend_mis;
    pend_mis = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_read_i    = 1'b0;
      mem_write_i   = 1'b0;
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = ($urandom_range(0, 3) == 0);
      dbus_rdata_i  = $urandom;
      exp_req       = 1'b0;
      exp_stall     = 1'b0;
      step();
    end
  endtask

  // One access: gnt g cycles after presentation, rvalid r cycles after gnt.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] w, input int g, input int r,
                           input logic [31:0] rd);
    bit done;
    mem_read_i  = ~st;
    mem_write_i = st;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = w;
    obs_be      = 4'h0;
    obs_addr    = 32'hFFFF_FFFF;
    obs_wdata   = 32'h0;
    obs_stall   = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (m_misaligned(st, f3, a)) begin
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b0;
      exp_req       = 1'b0;
      exp_stall     = 1'b0;
      pend_mis      = 1'b1;
      step();
      return;
    end
`endif
    exp_we    = st;
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = m_be(f3, a);
    exp_wdata = m_wdata(f3, w);
    done      = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      dbus_gnt_i = (c == g) || ((c > g) && (c < g + r) && ($urandom_range(0, 2) == 0));
      if (!st && (c == g + r)) begin
        dbus_rvalid_i = 1'b1;
        dbus_rdata_i  = rd;
        pend_valid    = 1'b1;
        pend_mem      = m_load(f3, a, rd);
      end else begin
        dbus_rvalid_i = (c < g) && ($urandom_range(0, 3) == 0);
        dbus_rdata_i  = $urandom;
      end
      exp_req   = (c <= g);
      exp_stall = st ? (c < g) : (c < g + r);
      done      = st ? (c == g) : (c == g + r);
      step();
    end
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0;
    addr_i = 32'h0; wdata_i = 32'h0; dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    dbus_rdata_i = 32'h0;
    #2;
    chk1("rst_req", dbus_req_o, 1'b0);
    chk1("rst_we", dbus_we_o, 1'b0);
    chk32("rst_addr", dbus_addr_o, 32'h0);
    chk32("rst_be", {28'h0, dbus_be_o}, 32'h0);
    chk32("rst_wdata", dbus_wdata_o, 32'h0);
    chk1("rst_stall", lsu_stall_o, 1'b0);
    chk32("rst_mem_o", mem_o, 32'h0);
    chk1("rst_mem_valid", mem_valid_o, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk1("rst_misalign", misalign_o, 1'b0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while waiting for gnt: request drops at once.
    mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h300;
    step();
    chk1("wg_req_before_rst", dbus_req_o, 1'b1);
    reset = 1'b1;
    #1;
    chk1("wg_req_in_rst", dbus_req_o, 1'b0);
    chk1("wg_stall_in_rst", lsu_stall_o, 1'b0);
    mem_read_i = 1'b0;
    step();
    reset = 1'b0;

    // Reset while waiting for the response; late rvalid is ignored.
    mem_read_i = 1'b1; funct3_i = 3'd2; addr_i = 32'h304; dbus_gnt_i = 1'b1;
    step();
    mem_read_i = 1'b0; dbus_gnt_i = 1'b0;
    chk1("wr_stall_before_rst", lsu_stall_o, 1'b1);
    reset = 1'b1;
    #1;
    chk1("wr_req_in_rst", dbus_req_o, 1'b0);
    chk1("wr_stall_in_rst", lsu_stall_o, 1'b0);
    step();
    reset = 1'b0;
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h89AB_CDEF;
    step();
    dbus_rvalid_i = 1'b0;
    chk1("late_rvalid_valid", mem_valid_o, 1'b0);
    chk32("late_rvalid_mem_o", mem_o, 32'h0);
    step();
    chk1("late_rvalid_valid2", mem_valid_o, 1'b0);
    model_mem = 32'h0;
    pend_valid = 1'b0;
    exp_valid = 1'b0;

    chk_en = 1'b1;
    idle(1);

    do_access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'h0);
    chk32("sw_be_lit", {28'h0, obs_be}, 32'hF);
    chk32("sw_addr_lit", obs_addr, 32'h100);
    chk32("sw_stall_cycles", obs_stall, 32'd0);

    do_access(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 2, 1, 32'h0);
    chk32("sb_be_lit", {28'h0, obs_be}, 32'h8);
    chk32("sb_wdata_lit", obs_wdata, 32'hA5A5_A5A5);
    chk32("sb_stall_cycles", obs_stall, 32'd2);

    do_access(1'b0, 3'd0, 32'h102, 32'h0, 0, 1, 32'h12F0_3456);
    chk32("lb_lit", mem_o, 32'hFFFF_FFF0);
    chk1("lb_valid_lit", mem_valid_o, 1'b1);
    do_access(1'b0, 3'd4, 32'h102, 32'h0, 1, 2, 32'h12F0_3456);
    chk32("lbu_lit", mem_o, 32'h0000_00F0);
    do_access(1'b0, 3'd1, 32'h202, 32'h0, 0, 1, 32'h8001_7FFF);
    chk32("lh_lit", mem_o, 32'hFFFF_8001);
    do_access(1'b0, 3'd5, 32'h202, 32'h0, 2, 1, 32'h8001_7FFF);
    chk32("lhu_lit", mem_o, 32'h0000_8001);
    idle(1);

    do_access(1'b0, 3'd2, 32'h101, 32'h0, 0, 1, 32'h5555_AAAA);
`ifdef LSU_MISALIGN_TRAP_EN
    chk1("lw_misalign_lit", misalign_o, 1'b1);
    chk32("lw_misalign_no_req", obs_addr, 32'hFFFF_FFFF);
`else
    chk32("lw_misalign_addr_lit", obs_addr, 32'h100);
    chk32("lw_misalign_data_lit", mem_o, 32'h5555_AAAA);
`endif
    idle(2);

    for (int i = 0; i < 200; i++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
